// File: rtl/i2c_status_pkg.sv
// i2c_status_pkg
//   Shared definitions for the I2C status-capture stage: the status word
//   width, the bit position of every status field, the set of bits consumed
//   by the interrupt logic, and the status word type.
package i2c_status_pkg;

  localparam int STATUS_W = 13;

  // Sticky (event) bit positions
  localparam int ST_TX_DONE      = 0;
  localparam int ST_RX_DONE      = 2;
  localparam int ST_NACK         = 3;
  localparam int ST_ARB_LOST     = 5;
  localparam int ST_STOP_DET     = 6;
  localparam int ST_RX_OVERFLOW  = 11;
  localparam int ST_TX_UNDERFLOW = 12;

  // Live (level) bit positions
  localparam int ST_BUSY      = 1;
  localparam int ST_BUS_BUSY  = 4;
  localparam int ST_TXF_FULL  = 7;
  localparam int ST_TXF_EMPTY = 8;
  localparam int ST_RXF_FULL  = 9;
  localparam int ST_RXF_EMPTY = 10;

  // Bits the downstream interrupt logic ORs together: 0, 2, 3, 5, 6
  localparam logic [STATUS_W-1:0] IRQ_SRC_MASK = 13'h006D;

  typedef logic [STATUS_W-1:0] status_t;

endpackage

// File: rtl/status_sticky_bit.sv
// status_sticky_bit
//   One sticky event bit: rising-edge detect on the event source plus a
//   set/write-1-to-clear flop. A same-cycle set beats a clear.
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset (clears edge history and bit)
//     evt  - raw event source level
//     clr  - qualified clear (write strobe AND the mask bit for this field)
//     rise - combinational rising-edge indication for this cycle
//     stat - registered sticky bit
module status_sticky_bit (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  input  logic clr,
  output logic rise,
  output logic stat
);

  logic prev;

  // prev starts at 0 after reset, so a source already high at release
  // counts as a fresh edge.
  assign rise = evt & ~prev;

  // Stage p1: edge history and sticky state
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      stat <= 1'b0;
    end else begin
      prev <= evt;
      stat <= rise | (stat & ~clr);
    end
  end

endmodule

// File: rtl/i2c_status_reg.sv
// i2c_status_reg
//   Status-capture stage of the APB I2C peripheral. Turns event strobes into
//   sticky W1C bits, registers the live FIFO/controller flags, and keeps a
//   saturating count of RX overflow edges. The status word feeds both the
//   interrupt logic and the APB read mux; no interrupt is generated here.
//   Ports:
//     clk        - system clock
//     rst        - synchronous active-high reset
//     sticky_evt - [0]TX_DONE [1]RX_DONE [2]NACK [3]ARB_LOST [4]STOP_DET
//                  [5]RX_OVERFLOW [6]TX_UNDERFLOW; a rising edge sets a bit
//     live_flags - [0]BUSY [1]BUS_BUSY [2]TXF_FULL [3]TXF_EMPTY [4]RXF_FULL
//                  [5]RXF_EMPTY; registered pass-through
//     clr_wr     - one-cycle write strobe to the status-clear address
//     clr_data   - W1C mask aligned to status bit positions
//     status     - registered 13-bit status word
//     ovf_count  - saturating count of RX_OVERFLOW edges (cleared via bit 11)
//   Optional feature macro I2C_STATUS_MASK_EN adds mask_wr/mask_data and a
//   mask register that hides interrupt-source bits from the status output.
module i2c_status_reg
  import i2c_status_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       sticky_evt,
  input  logic [5:0]       live_flags,
  input  logic             clr_wr,
  input  logic [12:0]      clr_data,
`ifdef I2C_STATUS_MASK_EN
  input  logic             mask_wr,
  input  logic [12:0]      mask_data,
`endif
  output logic [12:0]      status,
  output logic [CNT_W-1:0] ovf_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [6:0] evt_clr;
  logic [6:0] rise;
  logic [6:0] sticky_q;
  logic [5:0] live_p1;
  status_t    status_int;
  logic       ovf_clr;

  // Clear mask re-ordered from status positions to event index order
  assign evt_clr = {clr_data[ST_TX_UNDERFLOW], clr_data[ST_RX_OVERFLOW],
                    clr_data[ST_STOP_DET],     clr_data[ST_ARB_LOST],
                    clr_data[ST_NACK],         clr_data[ST_RX_DONE],
                    clr_data[ST_TX_DONE]} & {7{clr_wr}};

  // Live positions are read-only; their clear bits are intentionally ignored.
  logic unused_live_clr;
  assign unused_live_clr = ^{clr_data[ST_BUSY], clr_data[ST_BUS_BUSY],
                             clr_data[ST_TXF_FULL], clr_data[ST_TXF_EMPTY],
                             clr_data[ST_RXF_FULL], clr_data[ST_RXF_EMPTY]};

  for (genvar i = 0; i < 7; i++) begin : g_sticky
    status_sticky_bit u_bit (
      .clk  (clk),
      .rst  (rst),
      .evt  (sticky_evt[i]),
      .clr  (evt_clr[i]),
      .rise (rise[i]),
      .stat (sticky_q[i])
    );
  end

  assign ovf_clr = clr_wr & clr_data[ST_RX_OVERFLOW];

  // Stage p1: live flag register and overflow counter
  always_ff @(posedge clk) begin
    if (rst) begin
      live_p1   <= '0;
      ovf_count <= '0;
    end else begin
      live_p1 <= live_flags;
      // A clear that coincides with a new overflow edge keeps that edge.
      if (ovf_clr)
        ovf_count <= rise[5] ? CNT_W'(1) : '0;
      else if (rise[5])
        ovf_count <= sat_inc(ovf_count);
    end
  end

  always_comb begin
    status_int                  = '0;
    status_int[ST_TX_DONE]      = sticky_q[0];
    status_int[ST_RX_DONE]      = sticky_q[1];
    status_int[ST_NACK]         = sticky_q[2];
    status_int[ST_ARB_LOST]     = sticky_q[3];
    status_int[ST_STOP_DET]     = sticky_q[4];
    status_int[ST_RX_OVERFLOW]  = sticky_q[5];
    status_int[ST_TX_UNDERFLOW] = sticky_q[6];
    status_int[ST_BUSY]         = live_p1[0];
    status_int[ST_BUS_BUSY]     = live_p1[1];
    status_int[ST_TXF_FULL]     = live_p1[2];
    status_int[ST_TXF_EMPTY]    = live_p1[3];
    status_int[ST_RXF_FULL]     = live_p1[4];
    status_int[ST_RXF_EMPTY]    = live_p1[5];
  end

`ifdef I2C_STATUS_MASK_EN
  status_t mask_q;

  // Stage p1: mask register
  always_ff @(posedge clk) begin
    if (rst)
      mask_q <= 13'h1FFF;
    else if (mask_wr)
      mask_q <= mask_data;
  end

  // Masking is output-only: capture continues underneath, so unmasking
  // exposes an already-pending bit straight away.
  assign status = status_int & (mask_q | ~IRQ_SRC_MASK);
`else
  assign status = status_int;
`endif

endmodule

// File: tb/tb_i2c_status_reg.sv
// tb_i2c_status_reg
//   Directed testbench for i2c_status_reg: reset, edge-detect/hold-high,
//   set-vs-clear priority, counter saturation, live pass-through, mid-run
//   reset and (with I2C_STATUS_MASK_EN) interrupt-bit masking.
module tb_i2c_status_reg;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       sticky_evt;
  logic [5:0]       live_flags;
  logic             clr_wr;
  logic [12:0]      clr_data;
  logic [12:0]      status;
  logic [CNT_W-1:0] ovf_count;
`ifdef I2C_STATUS_MASK_EN
  logic             mask_wr;
  logic [12:0]      mask_data;
`endif

  int checks = 0;
  int errors = 0;

  i2c_status_reg #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sticky_evt (sticky_evt),
    .live_flags (live_flags),
    .clr_wr     (clr_wr),
    .clr_data   (clr_data),
`ifdef I2C_STATUS_MASK_EN
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
`endif
    .status     (status),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    sticky_evt = 7'h7F;
    live_flags = 6'h3F;
    clr_wr     = 1'b1;
    clr_data   = 13'h1FFF;
`ifdef I2C_STATUS_MASK_EN
    mask_wr    = 1'b0;
    mask_data  = 13'h1FFF;
`endif
    tick();
    tick();
    check("reset_status", 32'(status), 32'h0);
    check("reset_ovf", 32'(ovf_count), 32'h0);

    // Release with all events high: every sticky bit sets on the first edge
    rst        = 1'b0;
    live_flags = 6'h00;
    clr_wr     = 1'b0;
    clr_data   = 13'h0;
    tick();
    check("release_status", 32'(status), 32'h186D);
    check("release_ovf", 32'(ovf_count), 32'h1);

    sticky_evt = 7'h00;
    clr_wr     = 1'b1;
    clr_data   = 13'h1FFF;
    tick();
    check("clear_all_status", 32'(status), 32'h0);
    check("clear_all_ovf", 32'(ovf_count), 32'h0);
    clr_wr     = 1'b0;
    clr_data   = 13'h0;

    // NACK held high for 10 cycles, W1C in cycle 5
    sticky_evt = 7'h04;
    tick();
    check("hold_set", 32'(status), 32'h0008);
    tick(); tick(); tick();
    check("hold_still_set", 32'(status), 32'h0008);
    clr_wr   = 1'b1;
    clr_data = 13'h0008;
    tick();
    clr_wr   = 1'b0;
    clr_data = 13'h0;
    check("hold_cleared", 32'(status), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    check("hold_no_reset", 32'(status), 32'h0);
    sticky_evt = 7'h00;
    tick();
    sticky_evt = 7'h04;
    tick();
    check("hold_rearm", 32'(status), 32'h0008);
    sticky_evt = 7'h00;
    clr_wr     = 1'b1;
    clr_data   = 13'h1FFF;
    tick();
    clr_wr     = 1'b0;
    clr_data   = 13'h0;

    // Set beats a same-cycle clear on TX_DONE
    sticky_evt = 7'h01;
    tick();
    sticky_evt = 7'h00;
    tick();
    sticky_evt = 7'h01;
    clr_wr     = 1'b1;
    clr_data   = 13'h0001;
    tick();
    check("set_wins", 32'(status), 32'h0001);
    tick();
    check("clear_no_rise", 32'(status), 32'h0);
    clr_wr     = 1'b0;
    clr_data   = 13'h0;
    sticky_evt = 7'h00;
    tick();

    // RX_OVERFLOW counter
    for (int i = 0; i < 10; i++) begin
      sticky_evt = 7'h20; tick();
      sticky_evt = 7'h00; tick();
    end
    check("ovf_count_10", 32'(ovf_count), 32'd10);
    for (int i = 0; i < 290; i++) begin
      sticky_evt = 7'h20; tick();
      sticky_evt = 7'h00; tick();
    end
    check("ovf_saturate", 32'(ovf_count), 32'd255);
    check("ovf_sticky", 32'(status), 32'h0800);
    sticky_evt = 7'h20;
    clr_wr     = 1'b1;
    clr_data   = 13'h0800;
    tick();
    check("ovf_clr_rise", 32'(ovf_count), 32'd1);
    check("ovf_clr_rise_bit", 32'(status), 32'h0800);
    sticky_evt = 7'h00;
    tick();
    check("ovf_clr_only", 32'(ovf_count), 32'd0);
    check("ovf_clr_only_bit", 32'(status), 32'h0);
    clr_wr   = 1'b0;
    clr_data = 13'h0;

    // Live flag pass-through, immune to W1C
    live_flags = 6'b101010;
    tick();
    check("live_a", 32'(status), 32'h0510);
    clr_wr   = 1'b1;
    clr_data = 13'h1FFF;
    tick();
    check("live_w1c", 32'(status), 32'h0510);
    clr_wr     = 1'b0;
    clr_data   = 13'h0;
    live_flags = 6'b010101;
    tick();
    check("live_b", 32'(status), 32'h0282);
    live_flags = 6'h00;
    tick();

    // Reset in the middle of activity
    sticky_evt = 7'h7F;
    tick();
    check("pre_rst_status", 32'(status), 32'h186D);
    rst        = 1'b1;
    sticky_evt = 7'h00;
    live_flags = 6'h3F;
    tick();
    check("mid_rst_status", 32'(status), 32'h0);
    check("mid_rst_ovf", 32'(ovf_count), 32'h0);
    rst        = 1'b0;
    live_flags = 6'h00;
    tick();

`ifdef I2C_STATUS_MASK_EN
    mask_wr   = 1'b1;
    mask_data = 13'h1FDF;
    tick();
    mask_wr    = 1'b0;
    sticky_evt = 7'h04;
    tick();
    check("mask_nack", 32'(status), 32'h0008);
    sticky_evt = 7'h08;
    tick();
    check("mask_arb_hidden", 32'(status), 32'h0008);
    sticky_evt = 7'h00;
    mask_wr    = 1'b1;
    mask_data  = 13'h1FFF;
    tick();
    mask_wr    = 1'b0;
    check("mask_arb_exposed", 32'(status), 32'h0028);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
